// File: rtl/dlx_ctrl_window_checker_pkg.sv
// Shared constants, types and helpers for the UDLX control-window checker.
// Holds the default configuration, the channel index type and the latency/counter helpers.
package dlx_chk_pkg;

   localparam int N_CH_DEF    = 4;
   localparam int SIG_W_DEF   = 16;
   localparam int MIN_LAT_DEF = 1;
   localparam int MAX_LAT_DEF = 2;
   localparam int CNT_W_DEF   = 8;
   localparam int TS_W_DEF    = 16;

   typedef logic [$clog2(N_CH_DEF)-1:0] chk_ch_t;

   function automatic logic lat_cfg_ok(input int min_lat, input int max_lat);
      return (max_lat >= 1) && (min_lat >= 0) && (min_lat <= max_lat);
   endfunction

   // Saturates at the all-ones value of a counter that is 'width' bits wide.
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
      logic [31:0] max_v;
      max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (val >= max_v) ? max_v : val + 32'd1;
   endfunction

endpackage

// File: rtl/dlx_ctrl_window_checker_channel.sv
// One rule channel: attempt ageing register, window retire, fail decision,
// saturating error counter and sticky fail flag.
module dlx_chk_channel
   import dlx_chk_pkg::*;
#(
   parameter int SIG_W   = SIG_W_DEF,
   parameter int MIN_LAT = MIN_LAT_DEF,
   parameter int MAX_LAT = MAX_LAT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             trig_i,
   input  logic [SIG_W-1:0] mask_i,
   input  logic [SIG_W-1:0] obs_i,
   output logic             fail_now_o,
   output logic             fail_pulse_o,
   output logic             fail_sticky_o,
   output logic [CNT_W-1:0] err_cnt_o
);

   logic               match;
   logic [MAX_LAT:1]   aged;
   logic [MAX_LAT:1]   pend_q, pend_d;
   logic               pulse_q, pulse_d;
   logic               sticky_q, sticky_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   assign match = ((obs_i & mask_i) == mask_i);

   // A match retires every attempt whose age is inside the window; younger ones keep ageing.
   assign aged[1] = trig_i & ~(match & (MIN_LAT == 0));
   for (genvar k = 1; k < MAX_LAT; k++) begin : g_age
      localparam logic IN_WIN = (k >= MIN_LAT);
      assign aged[k+1] = pend_q[k] & ~(match & IN_WIN);
   end

   assign fail_now_o = en_i & ~clr_i & pend_q[MAX_LAT] & ~match;

   always_comb begin
      pend_d   = (en_i && !clr_i) ? aged : '0;
      pulse_d  = fail_now_o;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      if (clr_i) begin
         sticky_d = 1'b0;
         cnt_d    = '0;
      end else if (fail_now_o) begin
         sticky_d = 1'b1;
         cnt_d    = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_q   <= '0;
         pulse_q  <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         pend_q   <= pend_d;
         pulse_q  <= pulse_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end

   assign fail_pulse_o  = pulse_q;
   assign fail_sticky_o = sticky_q;
   assign err_cnt_o     = cnt_q;

endmodule

// File: rtl/dlx_ctrl_window_checker.sv
// Runtime checker for "trig |-> ##[MIN_LAT:MAX_LAT] (obs & mask)==mask" rules on the UDLX decode
// outputs: N_CH channels plus a free-running timestamp and first-failure capture.
module dlx_ctrl_window_checker
   import dlx_chk_pkg::*;
#(
   parameter int N_CH    = N_CH_DEF,
   parameter int SIG_W   = SIG_W_DEF,
   parameter int MIN_LAT = MIN_LAT_DEF,
   parameter int MAX_LAT = MAX_LAT_DEF,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int TS_W    = TS_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    clr,
   input  logic [N_CH-1:0]         trig,
   input  logic [N_CH*SIG_W-1:0]   mask,
   input  logic [SIG_W-1:0]        obs,
   output logic [N_CH-1:0]         fail_pulse,
   output logic [N_CH-1:0]         fail_sticky,
   output logic [N_CH*CNT_W-1:0]   err_cnt,
   output logic                    first_valid,
   output logic [$clog2(N_CH)-1:0] first_ch,
   output logic [TS_W-1:0]         first_ts
);

   localparam int CH_W = $clog2(N_CH);

   if (!lat_cfg_ok(MIN_LAT, MAX_LAT) || (N_CH < 2)) begin : g_bad_cfg
      $error("dlx_ctrl_window_checker: need 0<=MIN_LAT<=MAX_LAT, MAX_LAT>=1, N_CH>=2");
   end

   logic [N_CH-1:0] fail_now;
   logic [TS_W-1:0] ts_q, ts_d;
   logic            first_valid_q, first_valid_d;
   logic [CH_W-1:0] first_ch_q, first_ch_d, first_sel;
   logic [TS_W-1:0] first_ts_q, first_ts_d;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      dlx_chk_channel #(
         .SIG_W   (SIG_W),
         .MIN_LAT (MIN_LAT),
         .MAX_LAT (MAX_LAT),
         .CNT_W   (CNT_W)
      ) u_ch (
         .clk_i         (clk),
         .rst_ni        (rst_n),
         .en_i          (en),
         .clr_i         (clr),
         .trig_i        (trig[i]),
         .mask_i        (mask[i*SIG_W +: SIG_W]),
         .obs_i         (obs),
         .fail_now_o    (fail_now[i]),
         .fail_pulse_o  (fail_pulse[i]),
         .fail_sticky_o (fail_sticky[i]),
         .err_cnt_o     (err_cnt[i*CNT_W +: CNT_W])
      );
   end

   // Scan from the top so the lowest failing index is the one left standing.
   always_comb begin
      first_sel = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (fail_now[i]) first_sel = CH_W'(i);
      end
   end

   always_comb begin
      ts_d          = ts_q + TS_W'(1);
      first_valid_d = first_valid_q;
      first_ch_d    = first_ch_q;
      first_ts_d    = first_ts_q;
      if (clr) begin
         first_valid_d = 1'b0;
         first_ch_d    = '0;
         first_ts_d    = '0;
      end else if (!first_valid_q && (|fail_now)) begin
         first_valid_d = 1'b1;
         first_ch_d    = first_sel;
         first_ts_d    = ts_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_q          <= '0;
         first_valid_q <= 1'b0;
         first_ch_q    <= '0;
         first_ts_q    <= '0;
      end else begin
         ts_q          <= ts_d;
         first_valid_q <= first_valid_d;
         first_ch_q    <= first_ch_d;
         first_ts_q    <= first_ts_d;
      end
   end

   assign first_valid = first_valid_q;
   assign first_ch    = first_ch_q;
   assign first_ts    = first_ts_q;

endmodule

// File: tb/tb_dlx_ctrl_window_checker.sv
// Directed bench: default checker, a CNT_W=2 checker and a MIN_LAT=0/MAX_LAT=3 checker share one
// stimulus stream; each scenario checks the instance it targets.
module tb_dlx_ctrl_window_checker;
   import dlx_chk_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, en, clr;
   logic [3:0]  trig;
   logic [63:0] mask;
   logic [15:0] obs;

   logic [3:0]  d_pulse, d_sticky, c_pulse, c_sticky, l_pulse, l_sticky;
   logic [31:0] d_cnt, l_cnt;
   logic [7:0]  c_cnt;
   logic        d_fv, c_fv, l_fv;
   chk_ch_t     d_fch, c_fch, l_fch;
   logic [15:0] d_fts, c_fts, l_fts;

   int          n_checks = 0;
   int          n_err    = 0;
   int          ts_now   = 0;
   logic [15:0] ts_dec;

   always #5 clk = ~clk;

   dlx_ctrl_window_checker u_def (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .trig(trig), .mask(mask), .obs(obs),
      .fail_pulse(d_pulse), .fail_sticky(d_sticky), .err_cnt(d_cnt),
      .first_valid(d_fv), .first_ch(d_fch), .first_ts(d_fts)
   );

   dlx_ctrl_window_checker #(.CNT_W(2)) u_c2 (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .trig(trig), .mask(mask), .obs(obs),
      .fail_pulse(c_pulse), .fail_sticky(c_sticky), .err_cnt(c_cnt),
      .first_valid(c_fv), .first_ch(c_fch), .first_ts(c_fts)
   );

   dlx_ctrl_window_checker #(.MIN_LAT(0), .MAX_LAT(3)) u_l03 (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .trig(trig), .mask(mask), .obs(obs),
      .fail_pulse(l_pulse), .fail_sticky(l_sticky), .err_cnt(l_cnt),
      .first_valid(l_fv), .first_ch(l_fch), .first_ts(l_fts)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rst_n) ts_now++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; clr = 1'b0; trig = '0; obs = '0;
      mask  = {16'h1000, 16'h0100, 16'h0010, 16'h0003};
      #12;
      check_eq("rst_pulse",  32'(d_pulse),  32'h0);
      check_eq("rst_sticky", 32'(d_sticky), 32'h0);
      check_eq("rst_cnt",    d_cnt,         32'h0);
      check_eq("rst_fv",     32'(d_fv),     32'h0);
      check_eq("rst_fts",    32'(d_fts),    32'h0);
      rst_n = 1'b1; ts_now = 0; en = 1'b1;

      // 1: match at age 1 retires the attempt
      trig = 4'b0001; tick();
      trig = 4'b0000; obs = 16'h0003; tick();
      obs = 16'h0000; tick();
      check_eq("t1_pulse_a", 32'(d_pulse), 32'h0);
      tick();
      check_eq("t1_pulse_b", 32'(d_pulse), 32'h0);
      check_eq("t1_cnt",     d_cnt,        32'h0);

      // 2: no match in the window -> one fail pulse, first capture
      trig = 4'b0001; tick();
      trig = 4'b0000; tick();
      ts_dec = 16'(ts_now); tick();
      check_eq("t2_pulse",  32'(d_pulse),    32'h1);
      check_eq("t2_sticky", 32'(d_sticky),   32'h1);
      check_eq("t2_cnt",    d_cnt,           32'h1);
      check_eq("t2_fv",     32'(d_fv),       32'h1);
      check_eq("t2_fch",    32'(d_fch),      32'h0);
      check_eq("t2_fts",    32'(d_fts),      32'(ts_dec));
      tick();
      check_eq("t2_pulse_end", 32'(d_pulse), 32'h0);

      // 3a: two overlapping attempts, one match at t2 retires both
      trig = 4'b0010; obs = 16'h0000; tick();
      tick();
      trig = 4'b0000; obs = 16'h0010; tick();
      check_eq("t3a_pulse_a", 32'(d_pulse), 32'h0);
      obs = 16'h0000; tick();
      check_eq("t3a_pulse_b", 32'(d_pulse), 32'h0);
      tick();
      check_eq("t3a_pulse_c", 32'(d_pulse), 32'h0);
      check_eq("t3a_sticky",  32'(d_sticky), 32'h1);

      // 3b: match at t1 retires only the t0 attempt; the t1 attempt fails at t3
      trig = 4'b0010; tick();
      obs = 16'h0010; tick();
      trig = 4'b0000; obs = 16'h0000; tick();
      check_eq("t3b_pulse_t2", 32'(d_pulse), 32'h0);
      tick();
      check_eq("t3b_pulse_t3", 32'(d_pulse), 32'h2);
      check_eq("t3b_cnt1",     32'(d_cnt[15:8]), 32'h1);
      check_eq("t3b_fch",      32'(d_fch), 32'h0);

      // 4: simultaneous ch2/ch3 fail after clr, lowest index captured
      clr = 1'b1; tick();
      clr = 1'b0;
      check_eq("t4_clr_fv",     32'(d_fv),     32'h0);
      check_eq("t4_clr_cnt",    d_cnt,         32'h0);
      check_eq("t4_clr_sticky", 32'(d_sticky), 32'h0);
      trig = 4'b1100; tick();
      trig = 4'b0000; tick();
      ts_dec = 16'(ts_now); tick();
      check_eq("t4_pulse", 32'(d_pulse), 32'hC);
      check_eq("t4_cnt",   d_cnt,        32'h0101_0000);
      check_eq("t4_fch",   32'(d_fch),   32'h2);
      check_eq("t4_fts",   32'(d_fts),   32'(ts_dec));
      trig = 4'b0001; tick();
      trig = 4'b0000; tick();
      tick();
      check_eq("t4_late_pulse", 32'(d_pulse), 32'h1);
      check_eq("t4_late_fch",   32'(d_fch),   32'h2);
      check_eq("t4_late_fts",   32'(d_fts),   32'(ts_dec));

      // 5: CNT_W=2 saturation, then clr on a deciding edge
      clr = 1'b1; tick();
      clr = 1'b0;
      trig = 4'b0001; ticks(4);
      check_eq("t5_cnt2", 32'(c_cnt[1:0]), 32'h2);
      ticks(3);
      check_eq("t5_cnt_sat", 32'(c_cnt[1:0]), 32'h3);
      check_eq("t5_pulse",   32'(c_pulse),    32'h1);
      clr = 1'b1; tick();
      check_eq("t5_clr_pulse",  32'(c_pulse),  32'h0);
      check_eq("t5_clr_cnt",    32'(c_cnt),    32'h0);
      check_eq("t5_clr_fv",     32'(c_fv),     32'h0);
      check_eq("t5_clr_sticky", 32'(c_sticky), 32'h0);
      clr = 1'b0; trig = 4'b0000; ticks(3);
      check_eq("t5_post_pulse", 32'(c_pulse), 32'h0);
      check_eq("t5_post_cnt",   32'(c_cnt),   32'h0);

      // 6: MIN_LAT=0, MAX_LAT=3
      clr = 1'b1; tick();
      clr = 1'b0;
      trig = 4'b0001; obs = 16'h0003; tick();
      trig = 4'b0000; obs = 16'h0000; ticks(3);
      check_eq("t6_same_pulse", 32'(l_pulse), 32'h0);
      tick();
      check_eq("t6_same_sticky", 32'(l_sticky), 32'h0);
      trig = 4'b0001; tick();
      trig = 4'b0000; ticks(2);
      check_eq("t6_lat_early", 32'(l_pulse), 32'h0);
      tick();
      check_eq("t6_lat_fail",  32'(l_pulse), 32'h1);
      check_eq("t6_lat_cnt",   l_cnt,        32'h1);
      trig = 4'b0001; tick();
      trig = 4'b0000; en = 1'b0; tick();
      check_eq("t6_en_sticky", 32'(l_sticky), 32'h1);
      en = 1'b1; tick();
      check_eq("t6_en_pulse_a", 32'(l_pulse), 32'h0);
      ticks(2);
      check_eq("t6_en_pulse_b", 32'(l_pulse), 32'h0);
      check_eq("t6_en_cnt",     l_cnt,        32'h1);
      trig = 4'b0001; tick();
      trig = 4'b0000; tick();
      #2 rst_n = 1'b0;
      #1;
      check_eq("t6_arst_sticky", 32'(l_sticky), 32'h0);
      check_eq("t6_arst_cnt",    l_cnt,         32'h0);
      check_eq("t6_arst_fv",     32'(l_fv),     32'h0);
      check_eq("t6_arst_fts",    32'(l_fts),    32'h0);
      #3 rst_n = 1'b1; ts_now = 0;
      ticks(4);
      check_eq("t6_arst_nofail", 32'(l_pulse),  32'h0);
      check_eq("t6_arst_nostk",  32'(l_sticky), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
